// File: rtl/fft64_pkg.sv
// Shared FFT64 datapath parameters and the derived widths used by the
// sample collector and its lane bank.
package fft64_pkg;

   localparam int DW              = 10;
   localparam int LANES           = 8;
   localparam int WORDS_PER_FRAME = 8;

   localparam int IDX_W = $clog2(LANES);
   localparam int FRM_W = $clog2(WORDS_PER_FRAME);

   typedef logic [DW-1:0]       lane_t;
   typedef logic [LANES*DW-1:0] word_t;

endpackage

// File: rtl/shift_register8_collect_if.sv
// Streaming bus of the sample collector: sample input handshake on one side,
// packed word output handshake on the other.
interface shift_register8_collect_if
   import fft64_pkg::*;
   ();

   logic  in_valid;
   logic  in_ready;
   lane_t dinre;
   lane_t dinim;
   logic  out_valid;
   logic  out_ready;
   logic  out_last;
   word_t doutre;
   word_t doutim;

   // Producer of samples and consumer of packed words
   modport master (
      output in_valid, dinre, dinim, out_ready,
      input  in_ready, out_valid, out_last, doutre, doutim
   );

   // The collector itself
   modport slave (
      input  in_valid, dinre, dinim, out_ready,
      output in_ready, out_valid, out_last, doutre, doutim
   );

endinterface

// File: rtl/s2p_lane_bank.sv
// Assembly registers for one component (re or im). Only the first LANES-1
// lanes are stored: the final sample of a word bypasses the bank and goes
// straight into the output register together with these lanes.
module s2p_lane_bank
   import fft64_pkg::*;
   (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    we,
   input  logic [IDX_W-1:0]        idx,
   input  lane_t                   din,
   output logic [(LANES-1)*DW-1:0] word
   );

   lane_t lanes [LANES-1];

   // Write the accepted sample into its lane; clear wipes the partial word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LANES-1; k++) lanes[k] <= '0;
      end else if (clr) begin
         for (int k = 0; k < LANES-1; k++) lanes[k] <= '0;
      end else if (we && idx != IDX_W'(LANES-1)) begin
         lanes[idx] <= din;
      end
   end

   for (genvar k = 0; k < LANES-1; k++) begin : g_pack
      assign word[k*DW +: DW] = lanes[k];
   end

endmodule

// File: rtl/shift_register8_collect.sv
// Serial-to-parallel collector: packs LANES consecutive complex samples into
// one word per component and hands words downstream on valid/ready, tagging
// the last word of each FFT frame.
module shift_register8_collect
   import fft64_pkg::*;
   (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   shift_register8_collect_if.slave   bus
   );

   logic [IDX_W-1:0]        idx;
   logic [FRM_W-1:0]        wcnt;
   logic [(LANES-1)*DW-1:0] bank_re;
   logic [(LANES-1)*DW-1:0] bank_im;
   logic                    out_valid_q;
   logic                    out_last_q;
   word_t                   dout_re_q;
   word_t                   dout_im_q;
   logic                    last_lane;
   logic                    ready;
   logic                    accept;
   logic                    complete;

   assign last_lane = (idx == IDX_W'(LANES-1));
   assign ready     = !clr && !(last_lane && out_valid_q && !bus.out_ready);
   assign accept    = bus.in_valid && ready;
   assign complete  = accept && last_lane;

   s2p_lane_bank u_bank_re (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .we    (accept),
      .idx   (idx),
      .din   (bus.dinre),
      .word  (bank_re)
   );

   s2p_lane_bank u_bank_im (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .we    (accept),
      .idx   (idx),
      .din   (bus.dinim),
      .word  (bank_im)
   );

   // Lane index and frame position advance on accepted samples / completed words
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx  <= '0;
         wcnt <= '0;
      end else if (clr) begin
         idx  <= '0;
         wcnt <= '0;
      end else if (accept) begin
         if (last_lane) begin
            idx  <= '0;
            wcnt <= (wcnt == FRM_W'(WORDS_PER_FRAME-1)) ? '0 : wcnt + 1'b1;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   // Output register: loads a completed word, drains on handshake, holds otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         dout_re_q   <= '0;
         dout_im_q   <= '0;
      end else if (complete) begin
         out_valid_q <= 1'b1;
         out_last_q  <= (wcnt == FRM_W'(WORDS_PER_FRAME-1));
         dout_re_q   <= {bus.dinre, bank_re};
         dout_im_q   <= {bus.dinim, bank_im};
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.doutre    = dout_re_q;
   assign bus.doutim    = dout_im_q;

endmodule

// File: tb/tb_shift_register8_collect.sv
// Bench for the sample collector: a reference model of the lane assembly
// pushes expected words into a scoreboard queue as samples are accepted, and
// the head of the queue is compared whenever the DUT presents a word.
module tb_shift_register8_collect;
   import fft64_pkg::*;

   typedef struct packed {
      logic [LANES*DW-1:0] re;
      logic [LANES*DW-1:0] im;
      logic                last;
   } exp_word_t;

   logic clk;
   logic rst_n;
   logic clr;

   shift_register8_collect_if bus ();

   shift_register8_collect dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int                  n_tests = 0;
   int                  n_fail  = 0;
   exp_word_t           sb [$];
   logic [LANES*DW-1:0] m_re;
   logic [LANES*DW-1:0] m_im;
   int                  m_idx;
   int                  m_wcnt;
   logic                last_accept;
   int                  n_words;

   // Compare one observed value against the bench's expectation
   task automatic checkOutput(input string tag, input logic [LANES*DW-1:0] obs,
                              input logic [LANES*DW-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Forget all partial state in the reference model
   task automatic modelClear();
      m_re   = '0;
      m_im   = '0;
      m_idx  = 0;
      m_wcnt = 0;
   endtask

   // Drive one cycle of inputs, check outputs mid-cycle, then advance the model
   task automatic applyStimulus(input logic v, input logic [DW-1:0] re,
                                input logic [DW-1:0] im, input logic ordy,
                                input logic c);
      logic exp_ready;
      bus.in_valid  = v;
      bus.dinre     = re;
      bus.dinim     = im;
      bus.out_ready = ordy;
      clr           = c;
      @(negedge clk);
      exp_ready = !c && !(m_idx == LANES-1 && sb.size() != 0 && !ordy);
      checkOutput("in_ready", {79'd0, bus.in_ready}, {79'd0, exp_ready});
      checkOutput("out_valid", {79'd0, bus.out_valid}, {79'd0, sb.size() != 0});
      if (sb.size() != 0 && bus.out_valid) begin
         checkOutput("doutre", bus.doutre, sb[0].re);
         checkOutput("doutim", bus.doutim, sb[0].im);
         checkOutput("out_last", {79'd0, bus.out_last}, {79'd0, sb[0].last});
      end
      if (sb.size() != 0 && ordy) begin
         void'(sb.pop_front());
         n_words++;
      end
      last_accept = v && exp_ready;
      if (c) begin
         modelClear();
      end else if (last_accept) begin
         m_re[m_idx*DW +: DW] = re;
         m_im[m_idx*DW +: DW] = im;
         if (m_idx == LANES-1) begin
            sb.push_back('{re: m_re, im: m_im, last: (m_wcnt == WORDS_PER_FRAME-1)});
            m_idx  = 0;
            m_wcnt = (m_wcnt + 1) % WORDS_PER_FRAME;
         end else begin
            m_idx++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Idle cycles with the consumer ready, letting any pending word drain
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      logic [DW-1:0] neg;
      int            j;
      bus.in_valid  = 1'b0;
      bus.dinre     = '0;
      bus.dinim     = '0;
      bus.out_ready = 1'b0;
      clr           = 1'b0;
      rst_n         = 1'b0;
      n_words       = 0;
      modelClear();

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_out_valid", {79'd0, bus.out_valid}, 80'd0);
      checkOutput("rst_out_last", {79'd0, bus.out_last}, 80'd0);
      checkOutput("rst_in_ready", {79'd0, bus.in_ready}, 80'd1);
      checkOutput("rst_doutre", bus.doutre, 80'd0);
      checkOutput("rst_doutim", bus.doutim, 80'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic stream: re = 1..8, im = -1..-8
      for (int i = 1; i <= 8; i++) begin
         neg = DW'(-i);
         applyStimulus(1'b1, DW'(i), neg, 1'b1, 1'b0);
      end
      checkOutput("basic_lane0_re", {70'd0, bus.doutre[9:0]}, 80'd1);
      checkOutput("basic_lane7_re", {70'd0, bus.doutre[79:70]}, 80'd8);
      checkOutput("basic_lane0_im", {70'd0, bus.doutim[9:0]}, 80'h3FF);
      idle(2);

      // Backpressure: 16 samples offered while the consumer is stalled
      j = 0;
      for (int c = 0; c < 20; c++) begin
         applyStimulus(j < 16, DW'(100 + j), DW'(200 + j), c == 18, 1'b0);
         if (last_accept) j++;
      end
      checkOutput("bp_all_accepted", 80'(j), 80'd16);
      idle(3);

      // Full frame plus one word, aligned to a fresh frame by clr
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
      n_words = 0;
      for (int i = 0; i < 72; i++)
         applyStimulus(1'b1, DW'($urandom), DW'($urandom), 1'b1, 1'b0);
      idle(2);
      checkOutput("frame_words", 80'(n_words), 80'd9);

      // clr mid-word with a pending output word and a sample offered
      for (int i = 0; i < 11; i++)
         applyStimulus(1'b1, DW'(300 + i), DW'(400 + i), 1'b0, 1'b0);
      applyStimulus(1'b1, 10'h2AA, 10'h155, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b1, DW'(320 + i), DW'(420 + i), 1'b1, 1'b0);
      checkOutput("clr_lane0_re", {70'd0, bus.doutre[9:0]}, 80'd320);
      idle(2);

      // Async reset with a pending word and a partial word in flight
      for (int i = 0; i < 13; i++)
         applyStimulus(1'b1, DW'(500 + i), DW'(600 + i), 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_out_valid", {79'd0, bus.out_valid}, 80'd0);
      checkOutput("arst_out_last", {79'd0, bus.out_last}, 80'd0);
      checkOutput("arst_doutre", bus.doutre, 80'd0);
      sb.delete();
      modelClear();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b1, DW'(700 + i), DW'(800 + i), 1'b1, 1'b0);
      checkOutput("arst_lane0_re", {70'd0, bus.doutre[9:0]}, 80'd700);
      idle(2);

      checkOutput("sb_empty", 80'(sb.size()), 80'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
